// File: rtl/resq_dispatch_if.sv
// resq_dispatch_if: shelter/food request heads, dispatch offer, pop strobes.
// master = scheduler side, slave = queue/responder side.
interface resq_dispatch_if;
  logic       Shelter_Valid;
  logic       Shelter_Boost;
  logic [1:0] Shelter_Priority;
  logic [7:0] Shelter_Zone;
  logic       Food_Valid;
  logic       Food_Boost;
  logic [1:0] Food_Priority;
  logic [7:0] Food_Zone;
  logic       Disp_Valid;
  logic       Disp_Ready;
  logic       Disp_Class;
  logic       Disp_Boost;
  logic [1:0] Disp_Priority;
  logic [7:0] Disp_Zone;
  logic       Shelter_Pop;
  logic       Food_Pop;
  logic       Busy;

  modport master (
    input  Shelter_Valid, Shelter_Boost,
    input  Shelter_Priority, Shelter_Zone,
    input  Food_Valid, Food_Boost,
    input  Food_Priority, Food_Zone,
    input  Disp_Ready,
    output Disp_Valid, Disp_Class, Disp_Boost,
    output Disp_Priority, Disp_Zone,
    output Shelter_Pop, Food_Pop, Busy
  );

  modport slave (
    output Shelter_Valid, Shelter_Boost,
    output Shelter_Priority, Shelter_Zone,
    output Food_Valid, Food_Boost,
    output Food_Priority, Food_Zone,
    output Disp_Ready,
    input  Disp_Valid, Disp_Class, Disp_Boost,
    input  Disp_Priority, Disp_Zone,
    input  Shelter_Pop, Food_Pop, Busy
  );
endinterface

// File: rtl/resq_dispatch_scheduler.sv
// resq_dispatch_scheduler: arbitrates shelter/food heads onto one
// valid/ready dispatch channel with aging boost and a fairness cap.
// Ports: clk, rst_n (async, active low), bus (resq_dispatch_if.master):
//   request heads in, Disp_* offer out, Disp_Ready in, pops/Busy out.
module resq_dispatch_scheduler #(
  parameter int AGE_W      = 8,
  parameter int AGE_LIMIT  = 16,
  parameter int MAX_CONSEC = 4
) (
  input logic             clk,
  input logic             rst_n,
  resq_dispatch_if.master bus
);

  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam logic [AGE_W-1:0] LIM  = AGE_W'(AGE_LIMIT);
  localparam logic [CW-1:0]    CMAX = CW'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    POP   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [AGE_W-1:0] s_age, f_age;
  logic [CW-1:0]    consec;
  logic             last_class;

  logic       d_class;
  logic       d_boost;
  logic [1:0] d_prio;
  logic [7:0] d_zone;

  logic s_eb, f_eb;
  logic any_valid;
  logic pick_s;
  logic s_held, f_held;
  logic disp_valid, busy;
  logic s_pop, f_pop;

  assign s_eb = bus.Shelter_Boost | (s_age >= LIM);
  assign f_eb = bus.Food_Boost | (f_age >= LIM);
  assign any_valid = bus.Shelter_Valid | bus.Food_Valid;

  // Ordered rules: lone valid, fairness cap,
  // effective boost, priority, shelter on tie.
  always_comb begin
    pick_s = 1'b1;
    if (bus.Shelter_Valid && !bus.Food_Valid)
      pick_s = 1'b1;
    else if (!bus.Shelter_Valid && bus.Food_Valid)
      pick_s = 1'b0;
    else if (consec == CMAX)
      pick_s = ~last_class;
    else if (s_eb != f_eb)
      pick_s = s_eb;
    else if (bus.Shelter_Priority != bus.Food_Priority)
      pick_s = bus.Shelter_Priority > bus.Food_Priority;
    else
      pick_s = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_valid) state_nx = OFFER;
      OFFER:   if (bus.Disp_Ready) state_nx = POP;
      POP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    disp_valid = 1'b0;
    busy       = 1'b0;
    s_pop      = 1'b0;
    f_pop      = 1'b0;
    unique case (state)
      IDLE: ;
      OFFER: begin
        disp_valid = 1'b1;
        busy       = 1'b1;
      end
      POP: begin
        busy  = 1'b1;
        s_pop = d_class;
        f_pop = ~d_class;
      end
      default: ;
    endcase
  end

  assign bus.Disp_Valid    = disp_valid;
  assign bus.Busy          = busy;
  assign bus.Shelter_Pop   = s_pop;
  assign bus.Food_Pop      = f_pop;
  assign bus.Disp_Class    = d_class;
  assign bus.Disp_Boost    = d_boost;
  assign bus.Disp_Priority = d_prio;
  assign bus.Disp_Zone     = d_zone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_class <= 1'b0;
      d_boost <= 1'b0;
      d_prio  <= '0;
      d_zone  <= '0;
    end else if (state == IDLE && any_valid) begin
      d_class <= pick_s;
      d_boost <= pick_s ? s_eb : f_eb;
      d_prio  <= pick_s ? bus.Shelter_Priority
                        : bus.Food_Priority;
      d_zone  <= pick_s ? bus.Shelter_Zone
                        : bus.Food_Zone;
    end
  end

  // A class under offer (OFFER or POP) keeps its age frozen.
  assign s_held = (state != IDLE) & d_class;
  assign f_held = (state != IDLE) & ~d_class;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_age <= '0;
    end else if (!bus.Shelter_Valid || s_pop) begin
      s_age <= '0;
    end else if (!s_held && s_age < LIM) begin
      s_age <= s_age + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_age <= '0;
    end else if (!bus.Food_Valid || f_pop) begin
      f_age <= '0;
    end else if (!f_held && f_age < LIM) begin
      f_age <= f_age + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec     <= '0;
      last_class <= 1'b0;
    end else if (state == POP) begin
      if (d_class == last_class)
        consec <= (consec == CMAX) ? CMAX
                                   : consec + 1'b1;
      else
        consec <= CW'(1);
      last_class <= d_class;
    end
  end

endmodule
